// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helpers for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int unsigned C_DEF_MAX_BURST    = 16;
   localparam int unsigned C_DEF_IDLE_TIMEOUT = 64;

   // Index/counter width that never collapses to zero bits.
   function automatic int unsigned f_idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART TX FIFO write port, grouped for the arbiter.
interface uart_tx_arbiter_if
   import uart_arb_pkg::*;
#(
   parameter int unsigned C_NUM_REQ   = 4,
   parameter int unsigned C_DATA_BITS = 8
);
   localparam int unsigned C_IDX_W = f_idx_width(C_NUM_REQ);

   logic [C_NUM_REQ-1:0]             req_valid;
   logic [C_NUM_REQ*C_DATA_BITS-1:0] req_data;
   logic [C_NUM_REQ-1:0]             req_last;
   logic [C_NUM_REQ-1:0]             req_ready;
   logic [C_DATA_BITS-1:0]           TX_data;
   logic                             wr_uart_en;
   logic                             Full;
   logic [C_IDX_W-1:0]               grant_id;
   logic                             busy;

   modport master (
      input  req_valid, req_data, req_last, Full,
      output req_ready, TX_data, wr_uart_en, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, req_last, Full,
      input  req_ready, TX_data, wr_uart_en, grant_id, busy
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer, cyclically.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned C_NUM_REQ = 4,
   localparam int unsigned C_IDX_W  = f_idx_width(C_NUM_REQ)
) (
   input  logic [C_NUM_REQ-1:0] i_req,
   input  logic [C_IDX_W-1:0]   i_rr_ptr,
   output logic [C_IDX_W-1:0]   o_winner,
   output logic                 o_any_req
);

   logic [C_NUM_REQ-1:0] w_rot;
   logic [C_IDX_W-1:0]   w_off;
   logic [C_IDX_W:0]     w_sum;

   always_comb begin
      // Doubling the vector turns the cyclic search into a plain lowest-bit search.
      w_rot = C_NUM_REQ'({i_req, i_req} >> i_rr_ptr);
      w_off = '0;
      for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = C_IDX_W'(i);
      end
      w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
      if (w_sum >= (C_IDX_W + 1)'(C_NUM_REQ)) begin
         w_sum = w_sum - (C_IDX_W + 1)'(C_NUM_REQ);
      end
      o_winner  = w_sum[C_IDX_W-1:0];
      o_any_req = |i_req;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART TX FIFO write port with message, burst and idle release.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned C_NUM_REQ      = 4,
   parameter int unsigned C_DATA_BITS    = 8,
   parameter int unsigned C_MAX_BURST    = C_DEF_MAX_BURST,
   parameter int unsigned C_IDLE_TIMEOUT = C_DEF_IDLE_TIMEOUT
) (
   input logic               Clk,
   input logic               Reset,
   uart_tx_arbiter_if.master bus
);

   localparam int unsigned C_IDX_W   = f_idx_width(C_NUM_REQ);
   localparam int unsigned C_BURST_W = f_idx_width(C_MAX_BURST + 1);
   localparam int unsigned C_IDLE_W  = f_idx_width(C_IDLE_TIMEOUT + 1);

   state_t                 r_state;
   logic [C_IDX_W-1:0]     r_rr_ptr;
   logic [C_IDX_W-1:0]     r_grant_id;
   logic                   r_busy;
   logic                   r_wr_en;
   logic [C_DATA_BITS-1:0] r_tx_data;
   logic [C_BURST_W-1:0]   r_burst_cnt;
   logic [C_IDLE_W-1:0]    r_idle_cnt;

   logic [C_IDX_W-1:0]     w_winner;
   logic [C_IDX_W-1:0]     w_next_ptr;
   logic                   w_any;
   logic                   w_ready;
   logic                   w_valid_g;
   logic                   w_last_g;
   logic                   w_accept;
   logic                   w_burst_hit;
   logic                   w_idle_hit;
   logic                   w_release;
   logic [C_DATA_BITS-1:0] w_data_g;

   rr_arbiter #(
      .C_NUM_REQ (C_NUM_REQ)
   ) u_rr_arbiter (
      .i_req     (bus.req_valid),
      .i_rr_ptr  (r_rr_ptr),
      .o_winner  (w_winner),
      .o_any_req (w_any)
   );

   always_comb begin
      w_valid_g   = bus.req_valid[r_grant_id];
      w_last_g    = bus.req_last[r_grant_id];
      w_data_g    = bus.req_data[r_grant_id*C_DATA_BITS +: C_DATA_BITS];
      // Holding off while a write is presented lets Full always reflect the previous write.
      w_ready     = r_busy & ~bus.Full & ~r_wr_en;
      w_accept    = w_valid_g & w_ready;
      w_burst_hit = (C_MAX_BURST != 0) && ((32'(r_burst_cnt) + 32'd1) == C_MAX_BURST);
      w_idle_hit  = (C_IDLE_TIMEOUT != 0) && (32'(r_idle_cnt) == (C_IDLE_TIMEOUT - 1));
      w_release   = (w_accept & (w_last_g | w_burst_hit)) | (~w_valid_g & w_idle_hit);
      w_next_ptr  = (32'(r_grant_id) == (C_NUM_REQ - 1)) ? '0 : r_grant_id + C_IDX_W'(1);
      bus.req_ready = w_ready ? (C_NUM_REQ'(1) << r_grant_id) : '0;
   end

   assign bus.TX_data    = r_tx_data;
   assign bus.wr_uart_en = r_wr_en;
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = r_busy;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_busy      <= 1'b0;
         r_wr_en     <= 1'b0;
         r_tx_data   <= '0;
         r_burst_cnt <= '0;
         r_idle_cnt  <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant_id  <= w_winner;
                  r_state     <= GRANT;
                  r_busy      <= 1'b1;
                  r_burst_cnt <= '0;
                  r_idle_cnt  <= '0;
               end
            end
            GRANT: begin
               if (w_accept) begin
                  r_tx_data  <= w_data_g;
                  r_wr_en    <= 1'b1;
                  r_idle_cnt <= '0;
                  if (r_burst_cnt != '1) r_burst_cnt <= r_burst_cnt + C_BURST_W'(1);
               end else if (w_valid_g) begin
                  // Stalled by Full or the write slot is backpressure, not idleness.
                  r_idle_cnt <= '0;
               end else if (r_idle_cnt != '1) begin
                  r_idle_cnt <= r_idle_cnt + C_IDLE_W'(1);
               end
               if (w_release) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_rr_ptr <= w_next_ptr;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte scripts in, logged FIFO writes checked.
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   logic Clk;
   logic Reset;

   uart_tx_arbiter_if #(.C_NUM_REQ(4), .C_DATA_BITS(8)) bif ();

   uart_tx_arbiter #(
      .C_NUM_REQ      (4),
      .C_DATA_BITS    (8),
      .C_MAX_BURST    (16),
      .C_IDLE_TIMEOUT (64)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bif)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [8:0]  mem [4][32];
   int unsigned len [4];
   int unsigned idx [4];
   logic        en  [4];

   logic [7:0]  log_data [64];
   int          log_src  [64];
   int          log_cyc  [64];
   int          n_log;
   int          cyc;
   int          t0;
   int          n_checks;
   int          n_errs;
   int          bad_ready;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input logic rst);
      Reset = rst;
      for (int i = 0; i < 4; i++) begin
         if (en[i] && idx[i] < len[i]) begin
            bif.req_valid[i]         = 1'b1;
            bif.req_data[i*8 +: 8]   = mem[i][idx[i]][7:0];
            bif.req_last[i]          = mem[i][idx[i]][8];
         end else begin
            bif.req_valid[i]         = 1'b0;
            bif.req_data[i*8 +: 8]   = 8'h00;
            bif.req_last[i]          = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         if (!rst && bif.req_valid[i] && bif.req_ready[i]) idx[i]++;
      end
      if ((bif.req_ready & ~(4'b0001 << bif.grant_id)) != 4'b0000) bad_ready++;
      @(posedge Clk);
      #1;
      cyc++;
      if (bif.wr_uart_en && n_log < 64) begin
         log_data[n_log] = bif.TX_data;
         log_src[n_log]  = int'(bif.grant_id);
         log_cyc[n_log]  = cyc - t0;
         n_log++;
      end
   endtask

   task automatic start_test();
      for (int i = 0; i < 4; i++) begin
         len[i] = 0;
         idx[i] = 0;
         en[i]  = 1'b1;
      end
      bif.Full = 1'b0;
      tick(1'b1);
      tick(1'b1);
      n_log = 0;
      t0    = cyc;
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int b = 0;
      while (n_log < n && b < budget) begin
         tick(1'b0);
         b++;
      end
      check({tag, "_done"}, 32'(n_log >= n), 32'd1);
   endtask

   task automatic expect_write(input string tag, input int k, input int data, input int src,
                               input int c);
      check({tag, "_data"}, 32'(log_data[k]), 32'(data));
      check({tag, "_src"}, 32'(log_src[k]), 32'(src));
      if (c >= 0) check({tag, "_cyc"}, 32'(log_cyc[k]), 32'(c));
   endtask

   initial begin
      int n;
      int ready_hi;
      n_checks  = 0;
      n_errs    = 0;
      bad_ready = 0;
      cyc       = 0;
      n_log     = 0;
      t0        = 0;
      Reset     = 1'b1;
      bif.req_valid = '0;
      bif.req_data  = '0;
      bif.req_last  = '0;
      bif.Full      = 1'b0;

      // Reset state
      start_test();
      check("rst_busy", 32'(bif.busy), 32'd0);
      check("rst_wr", 32'(bif.wr_uart_en), 32'd0);
      check("rst_txd", 32'(bif.TX_data), 32'd0);
      check("rst_ready", 32'(bif.req_ready), 32'd0);
      check("rst_gid", 32'(bif.grant_id), 32'd0);

      // Single requester, 3-byte message
      start_test();
      mem[1][0] = {1'b0, 8'h41};
      mem[1][1] = {1'b0, 8'h42};
      mem[1][2] = {1'b1, 8'h43};
      len[1] = 3;
      run_until("t1", 3, 40);
      expect_write("t1_b0", 0, 'h41, 1, 2);
      expect_write("t1_b1", 1, 'h42, 1, 4);
      expect_write("t1_b2", 2, 'h43, 1, 6);
      check("t1_busy", 32'(bif.busy), 32'd0);
      check("t1_gid", 32'(bif.grant_id), 32'd1);

      // Four 2-byte messages in round-robin order, no interleave
      start_test();
      for (int i = 0; i < 4; i++) begin
         mem[i][0] = {1'b0, 8'(8'hA0 + 2 * i)};
         mem[i][1] = {1'b1, 8'(8'hA1 + 2 * i)};
         len[i] = 2;
      end
      run_until("t2", 8, 100);
      for (int k = 0; k < 8; k++) expect_write($sformatf("t2_w%0d", k), k, 'hA0 + k, k / 2, 2 + 2 * k);
      // Pointer wrapped to 0: requester 0 beats requester 3
      n_log = 0;
      mem[0][0] = {1'b1, 8'hC0};
      mem[3][0] = {1'b1, 8'hC3};
      for (int i = 0; i < 4; i++) idx[i] = 0;
      len[1] = 0;
      len[2] = 0;
      len[0] = 1;
      len[3] = 1;
      run_until("t2p", 2, 40);
      expect_write("t2p_w0", 0, 'hC0, 0, -1);
      expect_write("t2p_w1", 1, 'hC3, 3, -1);

      // Burst limit of 16 forces a handover to the pending requester
      start_test();
      for (int k = 0; k < 20; k++) mem[2][k] = {1'b0, 8'(k)};
      len[2] = 20;
      mem[3][0] = {1'b0, 8'hE0};
      mem[3][1] = {1'b1, 8'hE1};
      len[3] = 2;
      run_until("t3", 22, 200);
      for (int k = 0; k < 16; k++) expect_write($sformatf("t3_a%0d", k), k, k, 2, 2 + 2 * k);
      expect_write("t3_b0", 16, 'hE0, 3, 34);
      expect_write("t3_b1", 17, 'hE1, 3, 36);
      for (int k = 18; k < 22; k++) expect_write($sformatf("t3_c%0d", k), k, k - 2, 2, 38 + 2 * (k - 18));

      // Full held high mid-message: stall without loss or timeout
      start_test();
      mem[0][0] = {1'b0, 8'h51};
      mem[0][1] = {1'b0, 8'h52};
      mem[0][2] = {1'b0, 8'h53};
      mem[0][3] = {1'b1, 8'h54};
      len[0] = 4;
      run_until("t4a", 2, 40);
      bif.Full = 1'b1;
      ready_hi = 0;
      for (int k = 0; k < 100; k++) begin
         tick(1'b0);
         if (bif.req_ready != 4'b0000) ready_hi++;
      end
      check("t4_ready_full", 32'(ready_hi), 32'd0);
      check("t4_no_write", 32'(n_log), 32'd2);
      check("t4_busy_held", 32'(bif.busy), 32'd1);
      bif.Full = 1'b0;
      run_until("t4_resume", 3, 2);
      run_until("t4b", 4, 40);
      for (int k = 0; k < 4; k++) expect_write($sformatf("t4_w%0d", k), k, 'h51 + k, 0, -1);

      // Idle timeout releases after 64 cycles without valid
      start_test();
      mem[0][0] = {1'b0, 8'h61};
      len[0] = 1;
      mem[1][0] = {1'b1, 8'h71};
      len[1] = 1;
      run_until("t5a", 1, 20);
      n = 0;
      while (n < 200) begin
         tick(1'b0);
         n++;
         if (!bif.busy) break;
      end
      check("t5_idle_cycles", 32'(n), 32'd64);
      tick(1'b0);
      check("t5_regrant_busy", 32'(bif.busy), 32'd1);
      check("t5_regrant_gid", 32'(bif.grant_id), 32'd1);
      run_until("t5b", 2, 20);
      expect_write("t5_w1", 1, 'h71, 1, -1);

      // Reset on the edge that would register an accepted byte
      start_test();
      mem[2][0] = {1'b1, 8'h77};
      mem[2][1] = {1'b0, 8'h88};
      mem[2][2] = {1'b1, 8'h99};
      len[2] = 3;
      run_until("t6a", 1, 20);
      tick(1'b0);
      check("t6_granted", 32'(bif.busy), 32'd1);
      check("t6_ready", 32'(bif.req_ready), 32'b0100);
      tick(1'b1);
      check("t6_wr", 32'(bif.wr_uart_en), 32'd0);
      check("t6_busy", 32'(bif.busy), 32'd0);
      check("t6_gid", 32'(bif.grant_id), 32'd0);
      check("t6_txd", 32'(bif.TX_data), 32'd0);
      check("t6_rdy", 32'(bif.req_ready), 32'd0);
      check("t6_nlog", 32'(n_log), 32'd1);
      tick(1'b0);

      check("ready_only_grantee", 32'(bad_ready), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
